alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
//  Initiator side of the 4-bit ALU interface: drives alu_a/alu_b/alu_x and samples alu_out and flags.
//  Accepts ALU commands on a valid/ready stream, buffers them in a small FIFO and issues them one at a time.
//  Holds operands stable for SETTLE_CYCLES, captures result and flags, returns them on a valid/ready response stream.
//  Sits between the NPC test/exec front end and the combinational ALU.
// PARAMETERS
//  WIDTH          4  operand/result width; must match the ALU.
//  DEPTH          4  command FIFO entries; power of two, >=2.
//  SETTLE_CYCLES  1  cycles operands are held before capture; >=1.
// PORTS
//  clk            in   1      clock, rising edge.
//  rst            in   1      reset, synchronous, active-high.
//  cmd_valid      in   1      command present.
//  cmd_ready      out  1      FIFO not full.
//  cmd_op         in   3      000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor, 110 signed lt, 111 eq.
//  cmd_a, cmd_b   in   WIDTH  operands.
//  rsp_valid      out  1      response present.
//  rsp_ready      in   1      consumer accepts response.
//  rsp_data       out  WIDTH  captured alu_out.
//  rsp_ovf/rsp_zero/rsp_carry out 1 each  captured flags; forced 0 unless op is 000 or 001.
//  alu_a, alu_b   out  WIDTH  operands to ALU.
//  alu_x          out  3      opcode to ALU.
//  alu_out        in   WIDTH  ALU result.
//  alu_overflower, alu_zero, alu_carry_flag  in 1 each  ALU flags.
//  busy           out  1      FSM not IDLE or FIFO not empty.
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1 after reset; FIFO emptied, FSM to IDLE. Reset mid-operation drops in-flight command and all queued ones.
//  Push when cmd_valid&cmd_ready. Full: cmd_ready=0, no push. Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
//  FSM IDLE: FIFO non-empty -> pop head into operand regs, go DRIVE.
//  DRIVE: alu_a/b/x = registered operands; settle counter counts SETTLE_CYCLES, then CAPTURE.
//  CAPTURE: one cycle; register alu_out and masked flags into rsp regs; go RESP.
//  RESP: rsp_valid=1, rsp_* stable until rsp_ready. On handshake: FIFO non-empty -> pop, DRIVE; else IDLE.
//  Outside DRIVE/CAPTURE, alu_a/b/x hold their last value (no toggling).
//  Same-cycle push and pop allowed, including at full: pop frees slot only next cycle; at full, cmd_ready stays 0 that cycle.
//  Push into empty FIFO while IDLE: pop next cycle; min latency accept@t -> rsp_valid@t+3+SETTLE_CYCLES-1.
//  Commands complete strictly in order; one command in flight.
// CONFIGURATION
//  ALU_STICKY_STATUS_EN defined: extra outputs sticky_ovf, sticky_carry (1 bit each, reset 0);
//   set at CAPTURE of add/sub with the respective flag=1; cleared by input sticky_clr (1 bit), clear wins over same-cycle set.
//  Not defined: those ports and registers absent; behaviour otherwise identical.
// STRUCTURE
//  alu_pkg: opcode localparams (ALU_ADD..ALU_EQ), FSM state encoding (IDLE, DRIVE, CAPTURE, RESP), is_arith(op) function.
//  Sub-module alu_cmd_fifo (WIDTH*2+3 bits wide, DEPTH entries, push/pop/full/empty/count); FSM and capture in top.
// TESTING (bench instantiates the team 4-bit ALU as responder)
//  add a=7,b=1 -> rsp_data=8, rsp_ovf=1, rsp_carry=0, rsp_zero=0.
//  sub a=3,b=3 -> rsp_data=0, rsp_zero=1; xor a=5,b=5 -> rsp_data=0, rsp_zero=0 (masked).
//  push 5 commands back-to-back, rsp_ready=0 -> 4 accepted, cmd_ready=0 on 5th; release -> 4 responses in order.
//  hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable throughout; alu_* unchanged.
//  rst asserted in DRIVE with 2 queued -> next cycle rsp_valid=0, busy=0, cmd_ready=1; no stale responses later.
//  ALU_STICKY_STATUS_EN: add 7+1 then and 15&15 -> sticky_ovf=1 persists; sticky_clr pulse -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command issuer.
//   ALU_ADD..ALU_EQ : 3-bit opcodes presented on alu_x
//   state_e         : issuer FSM states (IDLE, DRIVE, CAPTURE, RESP)
//   is_arith(op)    : 1 for add/sub, the only ops whose flags are meaningful
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry synchronous FIFO holding packed {op, a, b} commands.
//   clk, rst         : clock, synchronous active-high reset (empties FIFO)
//   push_i, data_i   : write request/data; ignored when full
//   pop_i, data_o    : read request; data_o shows the head entry combinationally
//   full_o, empty_o  : status
//   count_o          : occupancy, clog2(DEPTH)+1 bits
module alu_cmd_fifo #(
  parameter int unsigned W     = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers are exactly AW bits, so DEPTH being a power of two gives free wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: initiator side of the combinational ALU interface.
// Buffers commands in a FIFO, drives one at a time onto alu_a/alu_b/alu_x,
// holds them SETTLE_CYCLES, captures result and flags, returns a response.
//   clk, rst                       : clock, synchronous active-high reset
//   cmd_valid/cmd_ready            : command stream; cmd_op, cmd_a, cmd_b payload
//   rsp_valid/rsp_ready            : response stream; rsp_data, rsp_ovf/zero/carry
//   alu_a, alu_b, alu_x            : operands/opcode to the ALU
//   alu_out, alu_overflower,
//   alu_zero, alu_carry_flag       : ALU result and flags
//   busy                           : command in flight or queued
// Optional (ALU_STICKY_STATUS_EN): sticky_clr in, sticky_ovf/sticky_carry out.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_x,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflower,
  input  logic             alu_zero,
  input  logic             alu_carry_flag,
  output logic             busy
`ifdef ALU_STICKY_STATUS_EN
  ,
  input  logic             sticky_clr,
  output logic             sticky_ovf,
  output logic             sticky_carry
`endif
);

  localparam int unsigned EW = 2*WIDTH + 3;
  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e              state_q;
  logic [CW-1:0]       settle_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [2:0]          op_q;
  logic                rsp_valid_q;
  logic [WIDTH-1:0]    rsp_data_q;
  logic                rsp_ovf_q;
  logic                rsp_zero_q;
  logic                rsp_carry_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [EW-1:0]       fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [2:0]          head_op;
  logic [WIDTH-1:0]    head_a;
  logic [WIDTH-1:0]    head_b;

  alu_cmd_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .data_i  ({cmd_op, cmd_a, cmd_b}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {head_op, head_a, head_b} = fifo_head;

  // Pop whenever the FSM is free to take the next command: from IDLE, or on
  // the response handshake so back-to-back commands skip IDLE.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      fifo_pop = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            a_q      <= head_a;
            b_q      <= head_b;
            op_q     <= head_op;
            settle_q <= '0;
            state_q  <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_q == CW'(SETTLE_CYCLES - 1)) begin
            state_q <= CAPTURE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        CAPTURE: begin
          rsp_data_q  <= alu_out;
          rsp_ovf_q   <= alu_overflower & is_arith(op_q);
          rsp_zero_q  <= alu_zero       & is_arith(op_q);
          rsp_carry_q <= alu_carry_flag & is_arith(op_q);
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (fifo_pop) begin
              a_q      <= head_a;
              b_q      <= head_b;
              op_q     <= head_op;
              settle_q <= '0;
              state_q  <= DRIVE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_STICKY_STATUS_EN
  logic sticky_ovf_q;
  logic sticky_carry_q;

  // Clear has priority over a set arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf_q   <= 1'b0;
      sticky_carry_q <= 1'b0;
    end else if (sticky_clr) begin
      sticky_ovf_q   <= 1'b0;
      sticky_carry_q <= 1'b0;
    end else if ((state_q == CAPTURE) && is_arith(op_q)) begin
      if (alu_overflower) sticky_ovf_q   <= 1'b1;
      if (alu_carry_flag) sticky_carry_q <= 1'b1;
    end
  end

  assign sticky_ovf   = sticky_ovf_q;
  assign sticky_carry = sticky_carry_q;
`endif

  // Operand registers only load on pop, so the ALU inputs hold their last
  // value outside DRIVE/CAPTURE.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_x     = op_q;
  assign cmd_ready = !fifo_full;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic       rsp_ovf, rsp_zero, rsp_carry;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_x;
  logic [3:0] alu_out;
  logic       alu_overflower, alu_zero, alu_carry_flag;
  logic       busy;
`ifdef ALU_STICKY_STATUS_EN
  logic       sticky_clr = 1'b0;
  logic       sticky_ovf, sticky_carry;
`endif

  int total  = 0;
  int passed = 0;
  int failed = 0;
  logic [6:0] sb [$];

  logic [2:0] fop [4] = '{3'd4, 3'd6, 3'd7, 3'd1};
  logic [3:0] fa  [4] = '{4'd9, 4'd14, 4'd6, 4'd2};
  logic [3:0] fb  [4] = '{4'd4, 4'd3, 4'd6, 4'd5};

  always #5 clk = ~clk;

  alu_cmd_issuer #(
    .WIDTH         (4),
    .DEPTH         (4),
    .SETTLE_CYCLES (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_ovf        (rsp_ovf),
    .rsp_zero       (rsp_zero),
    .rsp_carry      (rsp_carry),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_x          (alu_x),
    .alu_out        (alu_out),
    .alu_overflower (alu_overflower),
    .alu_zero       (alu_zero),
    .alu_carry_flag (alu_carry_flag),
    .busy           (busy)
`ifdef ALU_STICKY_STATUS_EN
    ,
    .sticky_clr     (sticky_clr),
    .sticky_ovf     (sticky_ovf),
    .sticky_carry   (sticky_carry)
`endif
  );

  // Reference 4-bit ALU: returns {out, ovf, zero, carry}; zero is reported for every op.
  function automatic logic [6:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       v;
    logic       c;
    s = '0; r = '0; v = 1'b0; c = 1'b0;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      3'b001: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
      3'b010: r = ~a;
      3'b011: r = a & b;
      3'b100: r = a | b;
      3'b101: r = a ^ b;
      3'b110: r = {3'b000, ($signed(a) < $signed(b))};
      default: r = {3'b000, (a == b)};
    endcase
    return {r, v, (r == 4'd0), c};
  endfunction

  // Expected response: flags only survive for add/sub.
  function automatic logic [6:0] exp_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [6:0] t;
    t = alu_f(op, a, b);
    if (op > 3'b001) t[2:0] = 3'b000;
    return t;
  endfunction

  assign {alu_out, alu_overflower, alu_zero, alu_carry_flag} = alu_f(alu_x, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Scoreboard: push on accepted command, pop/compare on response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("rsp_unexpected", 1, 0);
        else check("rsp_order", {25'd0, rsp_data, rsp_ovf, rsp_zero, rsp_carry}, {25'd0, sb.pop_front()});
      end
      if (cmd_valid && cmd_ready) sb.push_back(exp_f(cmd_op, cmd_a, cmd_b));
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait", rsp_valid, 1);
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp", {rsp_data, rsp_ovf, rsp_zero, rsp_carry}, 0);
    check("rst_alu", {alu_a, alu_b, alu_x}, 0);

    // add 7+1, minimum latency
    send(3'b000, 4'd7, 4'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lat_not_yet", rsp_valid, 0);
    end
    @(negedge clk);
    check("lat_valid", rsp_valid, 1);
    check("add_data", rsp_data, 8);
    check("add_ovf", rsp_ovf, 1);
    check("add_carry", rsp_carry, 0);
    check("add_zero", rsp_zero, 0);
    pulse_ready();

    send(3'b001, 4'd3, 4'd3);
    wait_rsp();
    check("sub_data", rsp_data, 0);
    check("sub_zero", rsp_zero, 1);
    pulse_ready();

    send(3'b101, 4'd5, 4'd5);
    wait_rsp();
    check("xor_data", rsp_data, 0);
    check("xor_zero_masked", rsp_zero, 0);
    pulse_ready();

`ifdef ALU_STICKY_STATUS_EN
    @(posedge clk); #1 sticky_clr = 1'b1;
    @(posedge clk); #1 sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_init", {sticky_ovf, sticky_carry}, 0);
    send(3'b000, 4'd7, 4'd1);
    wait_rsp();
    check("sticky_ovf_set", sticky_ovf, 1);
    check("sticky_carry_clear", sticky_carry, 0);
    pulse_ready();
    send(3'b011, 4'd15, 4'd15);
    wait_rsp();
    check("sticky_ovf_persist", sticky_ovf, 1);
    pulse_ready();
    @(posedge clk); #1 sticky_clr = 1'b1;
    @(posedge clk); #1 sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_cleared", {sticky_ovf, sticky_carry}, 0);
`endif

    // Fill: one command parked in RESP, four queued, fifth refused
    send(3'b011, 4'd12, 4'd10);
    wait_rsp();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_op = fop[i]; cmd_a = fa[i]; cmd_b = fb[i];
      @(negedge clk);
      check("fill_ready", cmd_ready, 1);
      @(posedge clk); #1;
    end
    cmd_op = 3'b000; cmd_a = 4'd1; cmd_b = 4'd1;
    @(negedge clk);
    check("full_block", cmd_ready, 0);
    check("full_busy", busy, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;

    // Response held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, 8);
      check("hold_alu", {alu_a, alu_b, alu_x}, {4'd12, 4'd10, 3'd3});
    end

    @(posedge clk); #1 rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_sb_empty", sb.size(), 0);
    check("drain_idle", busy, 0);
    @(posedge clk); #1 rsp_ready = 1'b0;

    // Reset while DRIVE with two commands still queued
    send(3'b000, 4'd1, 4'd2);
    wait_rsp();
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_op = 3'b100; cmd_a = 4'(i + 3); cmd_b = 4'd0;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("drive_operand", alu_a, 3);
    check("drive_busy", busy, 1);
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_stale", rsp_valid, 0);
    end

    // Recovery after reset
    send(3'b000, 4'd9, 4'd9);
    wait_rsp();
    check("recov_data", rsp_data, 2);
    check("recov_flags", {rsp_ovf, rsp_zero, rsp_carry}, 3'b101);
    repeat (3) @(negedge clk);
    check("recov_sb_empty", sb.size(), 0);
    check("recov_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
